// File: rtl/console_pkg.sv
// Shared types and constants for the console output arbiter.
// Benches use CHAR_CR / CHAR_LF as message terminators.
package console_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int DEFAULT_DATA_W = 8;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    // Successor of a requester index, wrapping modulo n.
    function automatic int next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid index at or above rr_ptr_i,
// wrapping modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_valid_o
);

    logic [IDX_W:0]   sum_s;
    logic [IDX_W-1:0] cand_s;
    logic             found_s;

    // Scan upward from the pointer; the first hit wins.
    always_comb begin
        idx_o   = '0;
        found_s = 1'b0;
        sum_s   = '0;
        cand_s  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum_s = {1'b0, rr_ptr_i} + (IDX_W+1)'(k);
            if (sum_s >= (IDX_W+1)'(N_REQ)) begin
                sum_s = sum_s - (IDX_W+1)'(N_REQ);
            end else begin
                sum_s = sum_s;
            end
            cand_s = sum_s[IDX_W-1:0];
            if (!found_s && valid_i[cand_s]) begin
                idx_o   = cand_s;
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign any_valid_o = |valid_i;

endmodule

// File: rtl/console_out_arbiter.sv
// Round-robin arbiter sharing one byte-wide console output among N_REQ requesters.
// Define CONSOLE_ARB_LOCK_EN to hold a grant until REQ_LAST or LOCK_TIMEOUT idle cycles.
module console_out_arbiter
    import console_pkg::*;
#(
    parameter int N_REQ        = 2,
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic                      CLK,
    input  logic                      RESETn,
    input  logic [N_REQ*DATA_W-1:0]   REQ_DATA,
    input  logic [N_REQ-1:0]          REQ_VALID,
    input  logic [N_REQ-1:0]          REQ_LAST,
    output logic [N_REQ-1:0]          REQ_READY,
    output logic [DATA_W-1:0]         CONSOLE_OUT,
    output logic                      CONSOLE_OUT_valid,
    input  logic                      CONSOLE_OUT_ready,
    output logic [$clog2(N_REQ)-1:0]  GRANT_ID,
    output logic                      BUSY
);

    localparam int IDX_W = $clog2(N_REQ);

    arb_state_e        state_q;
    logic [IDX_W-1:0]  grant_q;
    logic [IDX_W-1:0]  rr_ptr_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_full_q;

    logic [DATA_W-1:0] req_bytes_s [N_REQ];
    logic [IDX_W-1:0]  pick_idx_s;
    logic              pick_any_s;
    logic              gnt_valid_s;
    logic              gnt_ready_s;
    logic              accept_s;
    logic              release_s;

    // Unpack the flat data bus so the granted byte is a simple array read.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_bytes_s[i] = REQ_DATA[i*DATA_W +: DATA_W];
        end
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .valid_i     (REQ_VALID),
        .rr_ptr_i    (rr_ptr_q),
        .idx_o       (pick_idx_s),
        .any_valid_o (pick_any_s)
    );

    assign gnt_valid_s = REQ_VALID[grant_q];
    assign gnt_ready_s = (state_q == GRANT) && (!out_full_q || CONSOLE_OUT_ready);
    assign accept_s    = gnt_valid_s && gnt_ready_s;

`ifdef CONSOLE_ARB_LOCK_EN
    localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_q;
    logic             timeout_s;

    // Release fires on the edge where the idle count would reach LOCK_TIMEOUT.
    assign timeout_s = (state_q == GRANT) && !gnt_valid_s &&
                       (tmo_q == TMO_W'(LOCK_TIMEOUT - 1));
    assign release_s = (accept_s && REQ_LAST[grant_q]) || timeout_s;

    // Idle-cycle counter for the held grant; stalls under output backpressure.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            tmo_q <= '0;
        end else if ((state_q != GRANT) || accept_s || timeout_s) begin
            tmo_q <= '0;
        end else if (!gnt_valid_s) begin
            tmo_q <= tmo_q + TMO_W'(1);
        end
    end
`else
    logic unused_cfg_s;

    assign unused_cfg_s = (^REQ_LAST) ^ (LOCK_TIMEOUT > 1);
    assign release_s    = accept_s;
`endif

    // Arbitration FSM plus the single-entry output register.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            out_data_q <= '0;
            out_full_q <= 1'b0;
        end else begin
            if (accept_s) begin
                out_data_q <= req_bytes_s[grant_q];
                out_full_q <= 1'b1;
            end else if (out_full_q && CONSOLE_OUT_ready) begin
                out_full_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (pick_any_s) begin
                        state_q <= GRANT;
                        grant_q <= pick_idx_s;
                    end
                end
                GRANT: begin
                    if (release_s) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= IDX_W'(next_idx(int'(grant_q), N_REQ));
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign REQ_READY         = gnt_ready_s ? (N_REQ'(1) << grant_q) : '0;
    assign CONSOLE_OUT       = out_data_q;
    assign CONSOLE_OUT_valid = out_full_q;
    assign GRANT_ID          = grant_q;
    assign BUSY              = (state_q == GRANT) || out_full_q;

endmodule
